aunit_seq: RTL
==============

Name: aunit_seq

Overview:
- Sequencer for the PE arithmetic-unit array, which holds PEROW parallel multiply-accumulate lanes.
- Accepts one job configuration: taps per output and number of output passes.
- Streams input/weight operand beats from the PE buffers into the array under a valid/ready handshake.
- Drives the per-cycle clear/enable/last control, waits out the array pipeline latency, then presents a sum-valid handshake to the output collector before starting the next pass.

Parameters:
- CNTWD, 8, width of tap and pass counters; taps and passes each range 1..2^CNTWD-1.
- AU_LAT, 2, array latency in cycles from the last enabled beat to a stable o_Sum; must be at least 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_cfg_valid  in  1  job configuration valid.
- o_cfg_ready  out  1  sequencer idle; configuration accepted when valid and ready are both high.
- i_cfg_taps  in  CNTWD  MAC beats per output pass.
- i_cfg_passes  in  CNTWD  output passes per job.
- i_op_valid  in  1  operand buffers present an input/weight beat.
- o_op_ready  out  1  sequencer consumes the beat this cycle.
- o_au_clr  out  1  clear accumulators; one-cycle pulse at pass start.
- o_au_en  out  1  accumulate the current operand beat; equals i_op_valid & o_op_ready.
- o_au_last  out  1  current enabled beat is the last tap of the pass.
- o_sum_valid  out  1  o_Sum is stable and ready for collection.
- i_sum_ready  in  1  collector takes the sums.
- o_pass_idx  out  CNTWD  index of the current pass, 0-based.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle pulse after the final pass's sums are taken.

Behaviour:
- Reset value of every output is 0, except o_cfg_ready, which is 1 (IDLE).
- i_rst mid-job aborts immediately and discards all counters.
- All outputs are registered except o_au_en and o_op_ready.
- States: IDLE, CLR, ACC, DRAIN, OUT.
- IDLE:
  - o_cfg_ready=1.
  - On cfg handshake, latch taps and passes; pass_idx=0; go to CLR.
  - A configuration with taps=0 or passes=0 is accepted but ignored: stay IDLE, no o_done.
- CLR: o_au_clr=1 for exactly one cycle; tap_cnt=0; go to ACC. No operand is consumed in CLR.
- ACC:
  - o_op_ready=1.
  - Each handshake (o_au_en) increments tap_cnt.
  - o_au_last=1 with the enabled beat when tap_cnt==taps-1.
  - i_op_valid low stalls: no increment, o_au_en=0.
  - After the last beat, go to DRAIN with lat_cnt=0.
- DRAIN: o_op_ready=0; hold AU_LAT cycles counting lat_cnt; then go to OUT.
- OUT:
  - o_sum_valid=1 and held until i_sum_ready.
  - o_sum_valid must not drop or change without a handshake.
  - On handshake:
    - If pass_idx==passes-1: pulse o_done, go to IDLE.
    - Otherwise: pass_idx+1, go to CLR.
- Counters wrap-free: tap_cnt and lat_cnt never exceed taps-1 and AU_LAT-1.
- Minimum pass length is 1 + taps + AU_LAT + 1 cycles, with no stalls and i_sum_ready held high.
- i_cfg_valid outside IDLE is ignored (o_cfg_ready=0).
- taps=1: the first enabled beat also carries o_au_last.
- Back-to-back jobs: o_cfg_ready rises in the cycle after o_done; a new configuration may be accepted in that cycle.

Optional Feature:
- Macro AUSEQ_PERF_EN.
- When defined:
  - Adds output o_stall_cnt [15:0] and o_wait_cnt [15:0].
  - Both are cleared on cfg handshake and saturate at 16'hFFFF.
  - o_stall_cnt counts ACC cycles with i_op_valid=0.
  - o_wait_cnt counts OUT cycles with i_sum_ready=0.
  - Both hold their value after o_done.
- When not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic job: taps=4, passes=1, AU_LAT=2, i_op_valid and i_sum_ready tied 1, cfg accepted at cycle 0.
  - Expect o_au_clr at cycle 1, o_au_en at cycles 2-5, o_au_last at cycle 5, o_sum_valid at cycle 8.
  - Expect o_done at cycle 9 and o_cfg_ready=1 at cycle 10.
- Stalls: taps=3, i_op_valid pattern 1,0,0,1,1.
  - Exactly 3 o_au_en pulses, o_au_last on the 3rd; 2 stall cycles (perf build: o_stall_cnt=2).
- Multi-pass with backpressure: passes=3, i_sum_ready low 5 cycles in pass 1.
  - o_sum_valid held steady; o_pass_idx steps 0,1,2; o_au_clr pulses 3 times; single o_done.
- Edge configurations: taps=1 gives o_au_en and o_au_last in the same cycle. taps=0 or passes=0 gives no state change, o_busy stays 0, no o_done.
- Reset mid-ACC: assert i_rst at tap 2 of 4.
  - Next cycle: all outputs at reset values, o_cfg_ready=1.
  - New job taps=2 then completes normally.
- Config while busy: i_cfg_valid pulsed during DRAIN with taps=7 is ignored; the current job's pass length is unchanged.

Source files
------------

// File: rtl/aunit_seq.sv
// aunit_seq: job sequencer for the PE multiply-accumulate array.
// Walks CLR -> ACC -> DRAIN -> OUT once per output pass, for the configured
// number of passes, then pulses o_done and returns to IDLE.
// Optional build macro AUSEQ_PERF_EN adds stall/wait performance counters.
module aunit_seq #(
    parameter int CNTWD  = 8,
    parameter int AU_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CNTWD-1:0] i_cfg_taps,
    input  logic [CNTWD-1:0] i_cfg_passes,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    output logic             o_au_clr,
    output logic             o_au_en,
    output logic             o_au_last,
    output logic             o_sum_valid,
    input  logic             i_sum_ready,
    output logic [CNTWD-1:0] o_pass_idx,
    output logic             o_busy,
    output logic             o_done
`ifdef AUSEQ_PERF_EN
    ,
    output logic [15:0]      o_stall_cnt,
    output logic [15:0]      o_wait_cnt
`endif
);

    localparam int LATW = (AU_LAT > 1) ? $clog2(AU_LAT) : 1;
    localparam logic [LATW-1:0]  LAT_LAST = LATW'(AU_LAT - 1);
    localparam logic [LATW-1:0]  LAT_ONE  = LATW'(1);
    localparam logic [CNTWD-1:0] ONE      = CNTWD'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNTWD-1:0] taps_q, taps_d;
    logic [CNTWD-1:0] passes_q, passes_d;
    logic [CNTWD-1:0] pass_q, pass_d;
    logic [CNTWD-1:0] tap_q, tap_d;
    logic [LATW-1:0]  lat_q, lat_d;
    logic             done_d;
    logic             cfg_hs;

    // Registered outputs are computed from the next state so they line up
    // with the cycle the state machine actually occupies.
    logic cfg_ready_q, cfg_ready_d;
    logic clr_q, clr_d;
    logic last_q, last_d;
    logic sv_q, sv_d;
    logic busy_q, busy_d;
    logic done_q;

    // Operand handshake is combinational so a beat is consumed in the cycle it is offered.
    always_comb begin
        o_op_ready = (state_q == ACC);
        o_au_en    = i_op_valid & o_op_ready;
    end

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        taps_d   = taps_q;
        passes_d = passes_q;
        pass_d   = pass_q;
        tap_d    = tap_q;
        lat_d    = lat_q;
        done_d   = 1'b0;
        cfg_hs   = 1'b0;
        case (state_q)
            IDLE: begin
                // cfg_ready_q is low in the o_done cycle, which blocks acceptance there.
                if (i_cfg_valid && cfg_ready_q) begin
                    cfg_hs = 1'b1;
                    // A zero-sized job is consumed but produces no work.
                    if (i_cfg_taps != '0 && i_cfg_passes != '0) begin
                        taps_d   = i_cfg_taps;
                        passes_d = i_cfg_passes;
                        pass_d   = '0;
                        state_d  = CLR;
                    end
                end
            end
            CLR: begin
                tap_d   = '0;
                state_d = ACC;
            end
            ACC: begin
                if (o_au_en) begin
                    if (tap_q == taps_q - ONE) begin
                        lat_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        tap_d = tap_q + ONE;
                    end
                end
            end
            DRAIN: begin
                if (lat_q == LAT_LAST) begin
                    state_d = OUT;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            OUT: begin
                if (i_sum_ready) begin
                    if (pass_q == passes_q - ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        pass_d  = pass_q + ONE;
                        state_d = CLR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cfg_ready_d = (state_d == IDLE) && !done_d;
        clr_d       = (state_d == CLR);
        last_d      = (state_d == ACC) && (tap_d == taps_d - ONE);
        sv_d        = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            tap_q       <= '0;
            lat_q       <= '0;
            cfg_ready_q <= 1'b1;
            clr_q       <= 1'b0;
            last_q      <= 1'b0;
            sv_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            tap_q       <= tap_d;
            lat_q       <= lat_d;
            cfg_ready_q <= cfg_ready_d;
            clr_q       <= clr_d;
            last_q      <= last_d;
            sv_q        <= sv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Latched job sizes; only meaningful once a non-empty job is accepted.
    always_ff @(posedge i_clk) begin
        taps_q   <= taps_d;
        passes_q <= passes_d;
    end

    assign o_cfg_ready = cfg_ready_q;
    assign o_au_clr    = clr_q;
    assign o_au_last   = last_q;
    assign o_sum_valid = sv_q;
    assign o_pass_idx  = pass_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

`ifdef AUSEQ_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_q, stall_d;
    logic [15:0] wait_q, wait_d;

    // Stall/wait counters restart with each accepted configuration and hold afterwards.
    always_comb begin
        stall_d = stall_q;
        wait_d  = wait_q;
        if (cfg_hs) begin
            stall_d = '0;
            wait_d  = '0;
        end else begin
            if (state_q == ACC && !i_op_valid) stall_d = sat_inc(stall_q);
            if (state_q == OUT && !i_sum_ready) wait_d = sat_inc(wait_q);
        end
    end

    // Performance counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
            wait_q  <= '0;
        end else begin
            stall_q <= stall_d;
            wait_q  <= wait_d;
        end
    end

    assign o_stall_cnt = stall_q;
    assign o_wait_cnt  = wait_q;
`endif

endmodule
